// File: rtl/arcdvi_pkg.sv
// Shared constants for the ArcDVI capture top: register map, SPI command codes
// and the positions of the fields inside the 48-bit SPI frame.
package arcdvi_pkg;

    localparam logic [11:0] ADDR_VIDC_BASE = 12'h000;
    localparam logic [11:0] ADDR_ID        = 12'h800;
    localparam logic [11:0] ADDR_STATUS    = 12'h804;
    localparam logic [11:0] ADDR_CTRL      = 12'h808;
    localparam logic [11:0] ADDR_DMA       = 12'h80C;

    localparam logic [1:0] SPI_CMD_READ  = 2'b00;
    localparam logic [1:0] SPI_CMD_WRITE = 2'b01;

    localparam logic [5:0] SPI_FRAME_BITS = 6'd48;
    localparam logic [5:0] SPI_HDR_BITS   = 6'd16;

    // Frame bit positions; the header is extracted once 16 bits have arrived,
    // so header fields are addressed relative to bit 32 of the frame.
    localparam int FRAME_CMD_MSB  = 47;
    localparam int FRAME_ADDR_MSB = 45;
    localparam int FRAME_ADDR_LSB = 34;
    localparam int FRAME_HDR_LSB  = 32;

    function automatic logic is_vidc_addr(input logic [11:0] addr);
        return addr[11:6] == ADDR_VIDC_BASE[11:6];
    endfunction

endpackage

// File: rtl/arcdvi_spi_slave.sv
// Mode-0 48-bit SPI slave running entirely in the system clock domain; the SPI
// pins are synchronised and only detected rising edges of sclk advance it.
module arcdvi_spi_slave
    import arcdvi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        spi_clk_i,
    input  logic        spi_ncs_i,
    input  logic        spi_din_i,
    output logic        spi_dout_o,
    output logic [11:0] addr_o,
    output logic        rd_strobe_o,
    output logic        wr_strobe_o,
    output logic [31:0] wdata_o,
    input  logic [31:0] rdata_i
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic [SYNC_STAGES-1:0] din_sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            ncs_sync_q  <= '1;
            din_sync_q  <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi_ncs_i};
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], spi_din_i};
        end
    end

    logic sclk_s, ncs_s, din_s, rise;
    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
    assign din_s  = din_sync_q[SYNC_STAGES-1];

    logic        sclk_prev_q;
    logic [5:0]  bit_cnt_q;
    logic [30:0] sh_q;
    logic [31:0] sh_next;
    logic [1:0]  cmd_q;
    logic [11:0] addr_q;
    logic [30:0] out_q;
    logic        dout_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] wdata_q;

    assign rise    = sclk_s & ~sclk_prev_q;
    assign sh_next = {sh_q, din_s};

    // Strobe interface: rd_strobe_o / wr_strobe_o are single-cycle pulses with
    // addr_o (and wdata_o for writes) valid in the same cycle; the register
    // file must present rdata_i combinationally during rd_strobe_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_prev_q <= 1'b0;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            cmd_q       <= SPI_CMD_READ;
            addr_q      <= '0;
            out_q       <= '0;
            dout_q      <= 1'b0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            sclk_prev_q <= sclk_s;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            if (ncs_s) begin
                bit_cnt_q <= '0;
                out_q     <= '0;
                dout_q    <= 1'b0;
            end else if (rd_q) begin
                out_q  <= rdata_i[30:0];
                dout_q <= rdata_i[31];
            end else if (rise && bit_cnt_q != SPI_FRAME_BITS) begin
                sh_q      <= sh_next[30:0];
                bit_cnt_q <= bit_cnt_q + 6'd1;
                if (bit_cnt_q >= SPI_HDR_BITS) begin
                    dout_q <= out_q[30];
                    out_q  <= {out_q[29:0], 1'b0};
                end
                if (bit_cnt_q == SPI_HDR_BITS - 6'd1) begin
                    cmd_q  <= sh_next[FRAME_CMD_MSB-FRAME_HDR_LSB -: 2];
                    addr_q <= sh_next[FRAME_ADDR_MSB-FRAME_HDR_LSB : FRAME_ADDR_LSB-FRAME_HDR_LSB];
                    rd_q   <= 1'b1;
                end
                if (bit_cnt_q == SPI_FRAME_BITS - 6'd1 && cmd_q == SPI_CMD_WRITE) begin
                    wr_q    <= 1'b1;
                    wdata_q <= sh_next;
                end
            end
        end
    end

    assign spi_dout_o  = dout_q;
    assign addr_o      = addr_q;
    assign rd_strobe_o = rd_q;
    assign wr_strobe_o = wr_q;
    assign wdata_o     = wdata_q;

endmodule

// File: rtl/soc_top_arcdvi.sv
// ArcDVI capture top: snoops the VIDC bus into a shadow register file, keeps
// frame/DMA statistics and serves everything to the MCU through the SPI slave.
module soc_top_arcdvi
    import arcdvi_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ID_VALUE    = 32'h41524344
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        spi_clk,
    input  logic        spi_ncs,
    input  logic        spi_din,
    output logic        spi_dout,
    input  logic [31:0] vidc_d,
    input  logic        vidc_nvidw,
    input  logic        vidc_nvcs,
    input  logic        vidc_nhs,
    input  logic        vidc_nsndrq,
    input  logic        vidc_nvidrq,
    input  logic        vidc_flybk,
    input  logic        vidc_ckin,
    input  logic        vidc_nsndak,
    input  logic        vidc_nvidak
);

    // Data and strobes share one synchroniser chain so vidc_d is seen in the
    // same cycle as the strobe edge; active-low pins reset to their idle level.
    localparam logic [40:0] SNOOP_IDLE = {32'h0, 5'b11111, 2'b00, 2'b11};

    logic [40:0] snoop_raw;
    logic [40:0] snoop_sync_q [SYNC_STAGES];
    logic [40:0] snoop_s;

    assign snoop_raw = {vidc_d, vidc_nvidw, vidc_nvcs, vidc_nhs, vidc_nsndrq,
                        vidc_nvidrq, vidc_flybk, vidc_ckin, vidc_nsndak, vidc_nvidak};

    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) snoop_sync_q[i] <= SNOOP_IDLE;
        end else begin
            snoop_sync_q[0] <= snoop_raw;
            for (int i = 1; i < SYNC_STAGES; i++) snoop_sync_q[i] <= snoop_sync_q[i-1];
        end
    end

    assign snoop_s = snoop_sync_q[SYNC_STAGES-1];

    logic [31:0] d_s;
    logic        nvidw_s, nvcs_s, nvidak_s;
    assign d_s      = snoop_s[40:9];
    assign nvidw_s  = snoop_s[8];
    assign nvcs_s   = snoop_s[7];
    assign nvidak_s = snoop_s[0];

    logic [11:0] spi_addr;
    logic        spi_rd_strobe, spi_wr_strobe;
    logic [31:0] spi_wdata, spi_rdata;

    arcdvi_spi_slave #(.SYNC_STAGES(SYNC_STAGES)) u_spi (
        .clk_i       (clk_in),
        .rst_i       (reset),
        .spi_clk_i   (spi_clk),
        .spi_ncs_i   (spi_ncs),
        .spi_din_i   (spi_din),
        .spi_dout_o  (spi_dout),
        .addr_o      (spi_addr),
        .rd_strobe_o (spi_rd_strobe),
        .wr_strobe_o (spi_wr_strobe),
        .wdata_o     (spi_wdata),
        .rdata_i     (spi_rdata)
    );

    // Reads have no side effects, so the read strobe is not needed here.
    logic unused_snoop;
    assign unused_snoop = ^{d_s[25:24], snoop_s[6:1], spi_rd_strobe};

    logic        nvidw_prev_q, nvcs_prev_q, nvidak_prev_q;
    logic        wr_edge, vs_edge, ak_edge;
    logic [23:0] shadow_q [64];
    logic [15:0] frame_q, dma_q, dma_last_q;
    logic [31:0] ctrl_q;
    logic        locked_q;

    assign wr_edge = nvidw_prev_q & ~nvidw_s;
    assign vs_edge = nvcs_prev_q & ~nvcs_s;
    assign ak_edge = nvidak_prev_q & ~nvidak_s;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            nvidw_prev_q  <= 1'b1;
            nvcs_prev_q   <= 1'b1;
            nvidak_prev_q <= 1'b1;
            for (int i = 0; i < 64; i++) shadow_q[i] <= '0;
            frame_q    <= '0;
            dma_q      <= '0;
            dma_last_q <= '0;
            ctrl_q     <= '0;
            locked_q   <= 1'b0;
        end else begin
            nvidw_prev_q  <= nvidw_s;
            nvcs_prev_q   <= nvcs_s;
            nvidak_prev_q <= nvidak_s;

            if (wr_edge) shadow_q[d_s[31:26]] <= d_s[23:0];

            if (vs_edge) begin
                frame_q    <= frame_q + 16'd1;
                dma_last_q <= dma_q;
                dma_q      <= '0;
            end else if (ak_edge && dma_q != 16'hFFFF) begin
                dma_q <= dma_q + 16'd1;
            end

            // An SPI write to ctrl takes priority over a coincident vsync.
            if (spi_wr_strobe && spi_addr == ADDR_CTRL) begin
                ctrl_q <= spi_wdata;
                if (!spi_wdata[0]) locked_q <= 1'b0;
            end else if (vs_edge && ctrl_q[0]) begin
                ctrl_q[0] <= 1'b0;
                locked_q  <= 1'b1;
            end
        end
    end

    always_comb begin
        spi_rdata = '0;
        if (is_vidc_addr(spi_addr)) begin
            spi_rdata = {8'h0, shadow_q[spi_addr[5:0]]};
        end else begin
            case (spi_addr)
                ADDR_ID:     spi_rdata = ID_VALUE;
                ADDR_STATUS: spi_rdata = {frame_q, 15'h0, locked_q};
                ADDR_CTRL:   spi_rdata = ctrl_q;
                ADDR_DMA:    spi_rdata = {16'h0, dma_last_q};
                default:     spi_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_soc_top_arcdvi.sv
// Directed bench for soc_top_arcdvi: drives the VIDC pins and an SPI master
// with fixed delays and checks register reads against hand-computed values.
module tb_soc_top_arcdvi;

    localparam int SPI_HALF = 200;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        spi_clk, spi_ncs, spi_din, spi_dout;
    logic [31:0] vidc_d;
    logic        vidc_nvidw, vidc_nvcs, vidc_nhs, vidc_nsndrq, vidc_nvidrq;
    logic        vidc_flybk, vidc_ckin, vidc_nsndak, vidc_nvidak;

    int n_checks = 0;
    int n_fail   = 0;

    soc_top_arcdvi dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .spi_clk     (spi_clk),
        .spi_ncs     (spi_ncs),
        .spi_din     (spi_din),
        .spi_dout    (spi_dout),
        .vidc_d      (vidc_d),
        .vidc_nvidw  (vidc_nvidw),
        .vidc_nvcs   (vidc_nvcs),
        .vidc_nhs    (vidc_nhs),
        .vidc_nsndrq (vidc_nsndrq),
        .vidc_nvidrq (vidc_nvidrq),
        .vidc_flybk  (vidc_flybk),
        .vidc_ckin   (vidc_ckin),
        .vidc_nsndak (vidc_nsndak),
        .vidc_nvidak (vidc_nvidak)
    );

    always #10 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic spi_xfer(input logic [1:0] cmd, input logic [11:0] addr,
                            input logic [31:0] data, input int nbits,
                            output logic [47:0] rx);
        logic [47:0] frame;
        frame   = {cmd, addr, 2'b00, data};
        rx      = '0;
        spi_ncs = 1'b0;
        #SPI_HALF;
        for (int i = 0; i < nbits; i++) begin
            spi_din = frame[47-i];
            #SPI_HALF;
            rx      = {rx[46:0], spi_dout};
            spi_clk = 1'b1;
            #SPI_HALF;
            spi_clk = 1'b0;
        end
        #SPI_HALF;
        spi_ncs = 1'b1;
        spi_din = 1'b0;
        #(4*SPI_HALF);
    endtask

    task automatic spi_read(input logic [11:0] addr, output logic [31:0] data);
        logic [47:0] rx;
        spi_xfer(2'b00, addr, 32'h0, 48, rx);
        data = rx[31:0];
    endtask

    task automatic spi_write(input logic [11:0] addr, input logic [31:0] data);
        logic [47:0] rx;
        spi_xfer(2'b01, addr, data, 48, rx);
    endtask

    task automatic vidc_write(input logic [31:0] data);
        vidc_d = data;
        #100;
        vidc_nvidw = 1'b0;
        #100;
        vidc_nvidw = 1'b1;
        #100;
    endtask

    task automatic vsync();
        vidc_nvcs = 1'b0;
        #200;
        vidc_nvcs = 1'b1;
        #200;
    endtask

    task automatic video_frame(input int lines);
        for (int l = 0; l < lines; l++) begin
            vidc_nhs = 1'b0;
            #60;
            vidc_nhs    = 1'b1;
            vidc_nvidrq = 1'b0;
            for (int a = 0; a < 4; a++) begin
                vidc_nvidak = 1'b0;
                #60;
                vidc_nvidak = 1'b1;
                #60;
            end
            vidc_nvidrq = 1'b1;
            #60;
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic [47:0] rx;
        logic [3:0]  v;

        reset = 1'b1;
        spi_clk = 1'b0; spi_ncs = 1'b1; spi_din = 1'b0;
        vidc_d = '0; vidc_nvidw = 1'b1; vidc_nvcs = 1'b1; vidc_nhs = 1'b1;
        vidc_nsndrq = 1'b1; vidc_nvidrq = 1'b1; vidc_flybk = 1'b0;
        vidc_ckin = 1'b0; vidc_nsndak = 1'b1; vidc_nvidak = 1'b1;
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        reset = 1'b0;
        repeat (4) @(negedge clk_in);

        check_eq("reset_dout", {31'h0, spi_dout}, 32'h0);
        spi_read(12'h800, rd); check_eq("id", rd, 32'h41524344);
        spi_read(12'h123, rd); check_eq("unmapped", rd, 32'h0);
        spi_read(12'h804, rd); check_eq("status_reset", rd, 32'h0);
        spi_read(12'h80C, rd); check_eq("dma_reset", rd, 32'h0);
        spi_read(12'h808, rd); check_eq("ctrl_reset", rd, 32'h0);

        vidc_write({6'h14, 2'b00, 24'h5a5a5a});
        vidc_write({6'h15, 2'b00, 24'hcace00});
        vidc_write({6'h16, 2'b11, 24'h123456});
        spi_read(12'h014, rd); check_eq("vidc_14", rd, 32'h005a5a5a);
        spi_read(12'h015, rd); check_eq("vidc_15", rd, 32'h00cace00);
        spi_read(12'h016, rd); check_eq("vidc_16_hi_ignored", rd, 32'h00123456);

        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            vidc_write({6'(i), 2'b00, 12'h000, v, v, v});
        end
        spi_read(12'h000, rd); check_eq("pal_0", rd, 32'h00000000);
        spi_read(12'h007, rd); check_eq("pal_7", rd, 32'h00000777);
        spi_read(12'h00F, rd); check_eq("pal_15", rd, 32'h00000fff);
        spi_read(12'h014, rd); check_eq("vidc_14_kept", rd, 32'h005a5a5a);

        spi_write(12'h808, 32'h1);
        spi_read(12'h808, rd); check_eq("ctrl_req_set", rd, 32'h1);
        spi_read(12'h804, rd); check_eq("status_unlocked", rd, 32'h0);
        vsync();
        spi_read(12'h808, rd); check_eq("ctrl_req_cleared", rd, 32'h0);
        spi_read(12'h804, rd); check_eq("status_locked", rd, 32'h00010001);

        spi_write(12'h808, 32'hdead0000);
        spi_read(12'h808, rd); check_eq("ctrl_scratch", rd, 32'hdead0000);
        spi_read(12'h804, rd); check_eq("status_unlock_on_0", rd, 32'h00010000);

        vsync();
        video_frame(480);
        vsync();
        spi_read(12'h80C, rd); check_eq("dma_last", rd, 32'd1920);
        spi_read(12'h804, rd); check_eq("frame_count", rd, 32'h00030000);

        spi_xfer(2'b01, 12'h808, 32'hffffffff, 20, rx);
        spi_read(12'h014, rd); check_eq("after_abort_14", rd, 32'h005a5a5a);
        spi_read(12'h808, rd); check_eq("after_abort_ctrl", rd, 32'hdead0000);

        spi_write(12'h014, 32'h00abcdef);
        spi_read(12'h014, rd); check_eq("shadow_ro", rd, 32'h005a5a5a);
        check_eq("idle_dout", {31'h0, spi_dout}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
